// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared UART types and oversampling constants.
// Rev     : 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int START_MID  = 7;

    // Right-align a shift register that was filled MSB-first from the line.
    function automatic logic [7:0] align_data(input logic [7:0] b, input int dbit);
        return b >> (8 - dbit);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_if
// Brief   : Line, baud tick and received-byte signals of the UART receiver.
// Rev     : 1.0
// ============================================================================
interface uart_rx_if;

    logic       rx;
    logic       s_tick;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;
    logic       parity_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_odd;

    modport master (
        output rx, s_tick, parity_odd,
        input  dout, rx_done_tick, frame_err, parity_err, busy
    );

    modport slave (
        input  rx, s_tick, parity_odd,
        output dout, rx_done_tick, frame_err, parity_err, busy
    );
`else
    modport master (
        output rx, s_tick,
        input  dout, rx_done_tick, frame_err, parity_err, busy
    );

    modport slave (
        input  rx, s_tick,
        output dout, rx_done_tick, frame_err, parity_err, busy
    );
`endif

endinterface
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
// Module  : uart_sync2
// Brief   : Generic two-flop synchroniser for asynchronous inputs, resets high.
// Rev     : 1.0
// ============================================================================
module uart_sync2 #(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx
// Brief   : 16x-oversampled UART receiver; optional parity via UART_RX_PARITY_EN.
// Rev     : 1.0
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic     clk,
    input  logic     reset_n,
    uart_rx_if.slave bus
);

    logic       rx_s;
    logic       r_rx_prev;
    rx_state_t  r_state;
    logic [4:0] r_s;
    logic [2:0] r_n;
    logic [7:0] r_b;
    logic [7:0] r_dout;
    logic       r_done;
    logic       r_frame_err;
    logic       r_busy;
`ifdef UART_RX_PARITY_EN
    logic       r_par;
    logic       r_odd;
    logic       r_parity_err;
`endif

    uart_sync2 #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync_rx (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (bus.rx),
        .q       (rx_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_prev   <= 1'b1;
            r_state     <= IDLE;
            r_s         <= 5'd0;
            r_n         <= 3'd0;
            r_b         <= 8'd0;
            r_dout      <= 8'd0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par        <= 1'b0;
            r_odd        <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_rx_prev <= rx_s;
            r_done    <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Edge-triggered arming keeps a held-low break from retriggering.
                    if (r_rx_prev && !rx_s) begin
                        r_state <= START;
                        r_s     <= 5'd0;
                        r_busy  <= 1'b1;
                    end
                end

                START: begin
                    if (bus.s_tick) begin
                        if (r_s == 5'(START_MID)) begin
                            r_s <= 5'd0;
                            if (!rx_s) begin
                                r_state <= DATA;
                                r_n     <= 3'd0;
`ifdef UART_RX_PARITY_EN
                                r_odd   <= bus.parity_odd;
`endif
                            end else begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_s <= r_s + 5'd1;
                        end
                    end
                end

                DATA: begin
                    if (bus.s_tick) begin
                        if (r_s == 5'(OVERSAMPLE - 1)) begin
                            r_s <= 5'd0;
                            r_b <= {rx_s, r_b[7:1]};
                            if (r_n == 3'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= PARITY;
`else
                                r_state <= STOP;
`endif
                            end else begin
                                r_n <= r_n + 3'd1;
                            end
                        end else begin
                            r_s <= r_s + 5'd1;
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bus.s_tick) begin
                        if (r_s == 5'(OVERSAMPLE - 1)) begin
                            r_s     <= 5'd0;
                            r_par   <= rx_s;
                            r_state <= STOP;
                        end else begin
                            r_s <= r_s + 5'd1;
                        end
                    end
                end
`endif

                STOP: begin
                    if (bus.s_tick) begin
                        if (r_s == 5'(SB_TICK - 1)) begin
                            r_s         <= 5'd0;
                            r_state     <= IDLE;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_dout      <= align_data(r_b, DBIT);
                            r_frame_err <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                            r_parity_err <= (^align_data(r_b, DBIT)) ^ r_par ^ r_odd;
`endif
                        end else begin
                            r_s <= r_s + 5'd1;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_s     <= 5'd0;
                end
            endcase
        end
    end

    assign bus.dout         = r_dout;
    assign bus.rx_done_tick = r_done;
    assign bus.frame_err    = r_frame_err;
    assign bus.busy         = r_busy;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err   = r_parity_err;
`else
    assign bus.parity_err   = 1'b0;
`endif

endmodule
`default_nettype wire
